// File: rtl/pea_pkg.sv
// pea_pkg -- shared PE array constants and types.
//   N_BITS                  : datapath width of operands and FU results
//   OPC_SLOT_DEPTH_DEFAULT  : default entries per operand-collector queue
//   data_t                  : one operand / result word
package pea_pkg;

   localparam int unsigned N_BITS                 = 16;
   localparam int unsigned OPC_SLOT_DEPTH_DEFAULT = 2;

   typedef logic [N_BITS-1:0] data_t;

endpackage : pea_pkg

// File: rtl/pe_operand_collector_if.sv
// pe_operand_collector_if -- operand/feedback/FU handshake bundle of the operand collector.
//   slave  : the collector side (consumes operands, drives FU operands)
//   master : the producer / FU side
// Signal names keep the collector's point of view (_i into it, _o out of it).
interface pe_operand_collector_if;
   import pea_pkg::*;

   logic  flush_i;
   data_t a_i;
   logic  a_valid_i;
   logic  a_ready_o;
   data_t b_i;
   logic  b_valid_i;
   logic  b_ready_o;
   logic  acc_loopback_i;
   data_t fb_i;
   logic  fb_valid_i;
   logic  fu_ready_i;
   data_t a_o;
   data_t b_o;
   logic  ops_valid_o;

   modport slave (
      input  flush_i, a_i, a_valid_i, b_i, b_valid_i, acc_loopback_i, fb_i, fb_valid_i,
             fu_ready_i,
      output a_ready_o, b_ready_o, a_o, b_o, ops_valid_o
   );

   modport master (
      output flush_i, a_i, a_valid_i, b_i, b_valid_i, acc_loopback_i, fb_i, fb_valid_i,
             fu_ready_i,
      input  a_ready_o, b_ready_o, a_o, b_o, ops_valid_o
   );

endinterface : pe_operand_collector_if

// File: rtl/opc_fifo.sv
// opc_fifo -- single operand queue of the operand collector.
// Ports:
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   flush_i        : empty the queue on the next edge (wins over push/pop)
//   push_i, din_i  : write request and data (ignored while full)
//   pop_i          : drop the head entry (ignored while empty)
//   full_o         : queue holds DEPTH entries (registered occupancy only)
//   empty_o        : queue holds no entries
//   head_o         : oldest entry; meaningless while empty_o
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module opc_fifo import pea_pkg::*; #(
   parameter int unsigned DEPTH = OPC_SLOT_DEPTH_DEFAULT
) (
   input  logic  clk_i,
   input  logic  rst_n_i,
   input  logic  flush_i,
   input  logic  push_i,
   input  data_t din_i,
   input  logic  pop_i,
   output logic  full_o,
   output logic  empty_o,
   output data_t head_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   data_t           mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign full_o  = (cnt_q == CntW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   // A full queue refuses a push even if it is popped in the same cycle.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: the head is only consumed while the queue is non-empty.
   always_ff @(posedge clk_i) begin
      if (rst_n_i && !flush_i && do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule : opc_fifo

// File: rtl/pe_operand_collector.sv
// pe_operand_collector -- gathers A and B operands for a functional unit and issues them as
// in-order pairs. B may instead come from the FU feedback register (accumulate loopback).
// Ports:
//   clk_i   : clock
//   rst_n_i : synchronous active-low reset
//   bus     : pe_operand_collector_if.slave
//             flush_i                 drop queued operands and pending feedback
//             a_i/a_valid_i/a_ready_o operand A stream (ready = A queue not full)
//             b_i/b_valid_i/b_ready_o operand B stream (ready = B queue not full)
//             acc_loopback_i          take B from the feedback register
//             fb_i/fb_valid_i         FU result feedback
//             fu_ready_i              FU accepts the current pair
//             a_o/b_o/ops_valid_o     operand pair to the FU
// Build option:
//   PE_OPC_BYPASS_EN  when defined, an empty channel forwards its input straight to the FU
//                     (0-cycle latency); otherwise every operand is registered first.
module pe_operand_collector import pea_pkg::*; #(
   parameter int unsigned SLOT_DEPTH = OPC_SLOT_DEPTH_DEFAULT
) (
   input logic                    clk_i,
   input logic                    rst_n_i,
   pe_operand_collector_if.slave  bus
);

   logic  a_full, a_empty, b_full, b_empty;
   data_t a_head, b_head;
   logic  a_push, a_pop, b_push, b_pop;
   logic  a_byp, b_byp;
   logic  a_avail, b_avail;
   logic  ops_valid, issue;
   data_t fb_q;
   logic  fb_avail_q;

`ifdef PE_OPC_BYPASS_EN
   assign a_byp = a_empty && bus.a_valid_i;
   // B bypass is irrelevant while B comes from the feedback register.
   assign b_byp = b_empty && bus.b_valid_i && !bus.acc_loopback_i;
`else
   assign a_byp = 1'b0;
   assign b_byp = 1'b0;
`endif

   assign a_avail   = !a_empty || a_byp;
   assign b_avail   = !b_empty || b_byp;
   assign ops_valid = a_avail && (bus.acc_loopback_i ? fb_avail_q : b_avail);
   assign issue     = ops_valid && bus.fu_ready_i;

   assign a_pop  = issue && !a_empty;
   assign b_pop  = issue && !bus.acc_loopback_i && !b_empty;
   // A bypassed operand that issues this cycle is consumed and never stored.
   assign a_push = bus.a_valid_i && !a_full && !(a_byp && issue);
   assign b_push = bus.b_valid_i && !b_full && !(b_byp && issue);

   assign bus.a_ready_o   = !a_full;
   assign bus.b_ready_o   = !b_full;
   assign bus.ops_valid_o = ops_valid;

   always_comb begin
      bus.a_o = a_empty ? '0 : a_head;
      if (bus.acc_loopback_i) begin
         bus.b_o = fb_q;
      end else begin
         bus.b_o = b_empty ? '0 : b_head;
      end
`ifdef PE_OPC_BYPASS_EN
      if (a_byp) bus.a_o = bus.a_i;
      if (b_byp) bus.b_o = bus.b_i;
`endif
   end

   opc_fifo #(
      .DEPTH (SLOT_DEPTH)
   ) u_fifo_a (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (bus.flush_i),
      .push_i  (a_push),
      .din_i   (bus.a_i),
      .pop_i   (a_pop),
      .full_o  (a_full),
      .empty_o (a_empty),
      .head_o  (a_head)
   );

   opc_fifo #(
      .DEPTH (SLOT_DEPTH)
   ) u_fifo_b (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (bus.flush_i),
      .push_i  (b_push),
      .din_i   (bus.b_i),
      .pop_i   (b_pop),
      .full_o  (b_full),
      .empty_o (b_empty),
      .head_o  (b_head)
   );

   // Feedback register: a new capture beats a same-cycle loopback consume, so the fresh
   // value stays available. Flush drops availability but keeps the stored value.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         fb_q       <= '0;
         fb_avail_q <= 1'b0;
      end else if (bus.flush_i) begin
         fb_avail_q <= 1'b0;
      end else if (bus.fb_valid_i) begin
         fb_q       <= bus.fb_i;
         fb_avail_q <= 1'b1;
      end else if (issue && bus.acc_loopback_i) begin
         fb_avail_q <= 1'b0;
      end
   end

endmodule : pe_operand_collector

// File: doc/pe_operand_collector.md
PE_OPERAND_COLLECTOR -- requirements
Module: pe_operand_collector

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk_i (one clock) and rst_n_i (reset, synchronous, active-low).
REQ-002 The block SHALL take parameters: SLOT_DEPTH, default 2, entries per operand queue; power of 2, >=2.
REQ-003 Ports SHALL be:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- flush_i  in  1  drop all queued operands
- a_i  in  N_BITS  operand A data
- a_valid_i  in  1  A offered
- a_ready_o  out  1  A accepted
- b_i  in  N_BITS  operand B data
- b_valid_i  in  1  B offered
- b_ready_o  out  1  B accepted
- acc_loopback_i  in  1  B sourced from feedback register
- fb_i  in  N_BITS  FU result feedback
- fb_valid_i  in  1  feedback valid
- fu_ready_i  in  1  FU can take operands
- a_o  out  N_BITS  operand A to FU
- b_o  out  N_BITS  operand B to FU
- ops_valid_o  out  1  operand pair valid

Function
REQ-004 Each operand channel SHALL own a FIFO of SLOT_DEPTH entries; push on valid&&ready; x_ready_o = !full.
REQ-005 Read/write pointers SHALL wrap modulo SLOT_DEPTH; occupancy counter SHALL be $clog2(SLOT_DEPTH)+1 bits.
REQ-006 A full FIFO SHALL NOT accept a push even when popped in the same cycle (ready depends only on registered occupancy).
REQ-007 Issue condition: ops_valid_o = A available && (acc_loopback_i ? fb_avail : B available).
REQ-008 On ops_valid_o && fu_ready_i, the A head SHALL pop; the B head SHALL pop only when acc_loopback_i=0; fb_avail SHALL clear when acc_loopback_i=1.
REQ-009 a_o/b_o SHALL be the FIFO heads (b_o = feedback register when acc_loopback_i=1); outputs SHALL hold stable while ops_valid_o && !fu_ready_i.
REQ-010 Feedback register SHALL capture fb_i on fb_valid_i and set fb_avail; a simultaneous set and clear SHALL leave fb_avail=1 with the new value.
REQ-011 flush_i SHALL, on the next edge, empty both FIFOs and clear fb_avail; flush SHALL take priority over same-cycle push/pop/capture.
REQ-012 Default issue latency SHALL be 1 cycle: operand accepted at edge N is visible at ops_valid_o after edge N.
REQ-013 Issue SHALL be in-order per channel; A and B pairs SHALL match by arrival order.

Reset
REQ-014 While rst_n_i=0 at a clock edge: FIFOs empty, pointers 0, fb register 0, fb_avail 0.
REQ-015 Reset values SHALL be ops_valid_o=0, a_o=b_o=0, and a_ready_o=b_ready_o=1 after the first reset edge.
REQ-016 Reset asserted mid-operation SHALL discard all queued operands without emitting ops_valid_o.

Configuration
REQ-017 With PE_OPC_BYPASS_EN defined, an empty channel SHALL forward x_i combinationally to the output (0-cycle latency); if issued that cycle, no entry is stored.
REQ-018 Without PE_OPC_BYPASS_EN, all operands SHALL be registered first (REQ-012); no combinational path from x_i/x_valid_i to outputs.

Structure
REQ-019 N_BITS SHALL come from pea_pkg; pea_pkg SHALL gain constant OPC_SLOT_DEPTH_DEFAULT.
REQ-020 Per-channel queue SHALL be sub-module opc_fifo (push/pop/full/empty/head), instantiated for A and B.

Verification
REQ-021 Pair issue: A=5 at cycle 0, B=7 at cycle 2, fu_ready_i=1 -> single ops_valid_o pulse at cycle 3 with a_o=5, b_o=7.
REQ-022 Backpressure: fu_ready_i=0, push A=1,2,3 with SLOT_DEPTH=2 -> a_ready_o=0 after 2 accepts, 3 held; release -> issue order 1,2,3.
REQ-023 Loopback: acc_loopback_i=1, fb_i=9 with fb_valid_i, A=4 -> a_o=4, b_o=9; B FIFO occupancy unchanged.
REQ-024 Flush: 2 A and 1 B queued, flush_i together with a new A push -> next cycle both empty, ops_valid_o=0, push dropped.
REQ-025 Bypass: with PE_OPC_BYPASS_EN, empty queues, A=3 and B=6 same cycle, fu_ready_i=1 -> ops_valid_o=1 that cycle, nothing stored; without it, ops_valid_o=1 one cycle later.
